// File: rtl/min_hour_counter.sv
// ---------------------------------------------------------------------------
// min_hour_counter
//
// Minutes/hours stage of a time-of-day clock. Counts minutes on each
// seconds-wrap pulse, carries into hours, and accepts a time load through a
// valid/ready handshake. A load is checked for range; a bad load leaves the
// time untouched and reports set_err.
//
// Optional feature: define MIN_HOUR_ALARM_EN to build the alarm comparator.
// Without it the alarm ports stay on the module, alarm is tied low and the
// alarm inputs have no effect.
//
// Parameters
//   HOURS_PER_DAY  hour wrap modulus, 1..24 (default 24)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   sec_wrap     one-cycle pulse from the seconds stage (59 -> 0)
//   set_valid    time-load request
//   set_hour     hour to load
//   set_min      minute to load
//   set_ready    high when a load can be accepted (FSM in RUN)
//   set_err      one-cycle pulse after an out-of-range load was accepted
//   minute       current minute, 0..59
//   hour         current hour, 0..HOURS_PER_DAY-1
//   min_tick     one-cycle pulse after minute wraps 59 -> 0
//   day_tick     one-cycle pulse after hour wraps to 0
//   alarm_hour   alarm compare hour
//   alarm_min    alarm compare minute
//   alarm_arm    alarm enable; dropping it clears a raised alarm
//   alarm        alarm flag
// ---------------------------------------------------------------------------
//
// Load FSM
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | counting, set_ready=1, a set_valid is taken as a transfer
//   ST_HOLD | one cycle after a transfer, set_ready=0, counting continues
// ---------------------------------------------------------------------------

module min_hour_counter #(
  parameter int HOURS_PER_DAY = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_wrap,
  input  logic       set_valid,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  output logic       set_ready,
  output logic       set_err,
  output logic [5:0] minute,
  output logic [4:0] hour,
  output logic       min_tick,
  output logic       day_tick,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_arm,
  output logic       alarm
);

  localparam logic [5:0] MIN_LAST  = 6'd59;
  localparam logic [4:0] HOUR_LAST = 5'(HOURS_PER_DAY - 1);
  localparam logic [4:0] HOUR_MOD  = 5'(HOURS_PER_DAY);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] minute_q, minute_d;
  logic [4:0] hour_q, hour_d;
  logic       min_tick_q, min_tick_d;
  logic       day_tick_q, day_tick_d;
  logic       set_err_q, set_err_d;

  logic       transfer;
  logic       load_ok;
  logic       count_step;

  assign transfer   = set_valid && (state_q == ST_RUN);
  assign load_ok    = (set_min <= MIN_LAST) && (set_hour < HOUR_MOD);
  // A transfer always wins over a coincident seconds pulse, good load or not.
  assign count_step = sec_wrap && !transfer;

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (transfer) state_d = ST_HOLD;
      ST_HOLD: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Time datapath and pulse outputs
  // -------------------------------------------------------------------------
  always_comb begin
    minute_d   = minute_q;
    hour_d     = hour_q;
    min_tick_d = 1'b0;
    day_tick_d = 1'b0;
    set_err_d  = 1'b0;

    if (transfer) begin
      if (load_ok) begin
        minute_d = set_min;
        hour_d   = set_hour;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (count_step) begin
      if (minute_q >= MIN_LAST) begin
        minute_d   = 6'd0;
        min_tick_d = 1'b1;
        // The >= compare keeps hour inside range even from a corrupted value.
        if (hour_q >= HOUR_LAST) begin
          hour_d     = 5'd0;
          day_tick_d = 1'b1;
        end else begin
          hour_d = hour_q + 5'd1;
        end
      end else begin
        minute_d = minute_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      minute_q   <= 6'd0;
      hour_q     <= 5'd0;
      min_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      minute_q   <= minute_d;
      hour_q     <= hour_d;
      min_tick_q <= min_tick_d;
      day_tick_q <= day_tick_d;
      set_err_q  <= set_err_d;
    end
  end

  assign set_ready = (state_q == ST_RUN);
  assign set_err   = set_err_q;
  assign minute    = minute_q;
  assign hour      = hour_q;
  assign min_tick  = min_tick_q;
  assign day_tick  = day_tick_q;

  // -------------------------------------------------------------------------
  // Alarm
  // -------------------------------------------------------------------------
`ifdef MIN_HOUR_ALARM_EN
  logic alarm_q, alarm_d;
  logic alarm_hit;

  // Compare against the value about to be loaded by a count step, so the
  // flag rises in the same cycle the matching time first shows. Loads never
  // raise it because count_step is low on a transfer.
  assign alarm_hit = count_step && (hour_d == alarm_hour) && (minute_d == alarm_min);

  always_comb begin
    alarm_d = alarm_q;
    if (!alarm_arm) begin
      alarm_d = 1'b0;
    end else if (alarm_hit) begin
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  // Alarm disabled: constant zero. The inputs are folded in only so they are
  // consumed; the AND with zero removes them entirely.
  assign alarm = 1'b0 & (^{alarm_hour, alarm_min, alarm_arm});
`endif

endmodule
